// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the neural-network weight path: fixed-point format,
// the weight loader FSM encoding and a small width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package nn_pkg;

    localparam int INT_WIDTH  = 8;
    localparam int FRAC_WIDTH = 8;

    // Signed fixed point; bit 0 is the LSB of the integer part.
    typedef logic signed [INT_WIDTH-1:-FRAC_WIDTH] fixed_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    // Counter width able to index 0..count-1; never returns zero so that a
    // single-entry count still yields a legal vector.
    function automatic int addr_bits(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/weight_ram_writer_if.sv
// -----------------------------------------------------------------------------
// weight_ram_writer_if
// Byte stream (valid/ready) into the weight loader plus the RAM write port it
// drives.
//   in_data / in_valid        : stream byte from upstream
//   in_ready                  : loader accepts a byte this cycle
//   write_enable              : RAM write strobe
//   write_address / write_data: RAM write address and word
// Modports: master = stream source / RAM side, slave = the loader.
// -----------------------------------------------------------------------------
interface weight_ram_writer_if
    import nn_pkg::*;
#(
    parameter int WIDTH = INT_WIDTH + FRAC_WIDTH,
    parameter int DEPTH = 784
);
    localparam int ADDR_WIDTH = addr_bits(DEPTH);

    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [WIDTH-1:0]      write_data;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  write_enable,
        input  write_address,
        input  write_data
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output write_enable,
        output write_address,
        output write_data
    );

endinterface

// File: rtl/byte_word_assembler.sv
// -----------------------------------------------------------------------------
// byte_word_assembler
// Collects accepted bytes little-endian into a WIDTH-bit word.
//   clock, reset  : clock, async active-low reset
//   clear         : drop any partial word and restart at byte 0
//   accept        : byte_in is consumed this cycle
//   byte_in       : stream byte
//   word_full     : assembled word including the byte being accepted now
//   word_complete : this accept supplies the last byte of the word
// -----------------------------------------------------------------------------
module byte_word_assembler
    import nn_pkg::*;
#(
    parameter int WIDTH = INT_WIDTH + FRAC_WIDTH
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             accept,
    input  logic [7:0]       byte_in,
    output logic [WIDTH-1:0] word_full,
    output logic             word_complete
);
    localparam int BYTES_PER_WORD = WIDTH / 8;
    localparam int CNT_WIDTH      = addr_bits(BYTES_PER_WORD);

    logic [CNT_WIDTH-1:0] byte_cnt;
    logic [WIDTH-1:0]     word_q;

    // Merge the incoming byte combinationally so the caller can register the
    // complete word on the same edge that accepts its last byte.
    always_comb begin
        word_full = word_q;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (accept && (byte_cnt == CNT_WIDTH'(k))) begin
                word_full[8*k +: 8] = byte_in;
            end
        end
    end

    assign word_complete = accept && (byte_cnt == CNT_WIDTH'(BYTES_PER_WORD - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_cnt <= '0;
            word_q   <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            word_q   <= '0;
        end else if (accept) begin
            word_q   <= word_full;
            byte_cnt <= word_complete ? '0 : byte_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/weight_ram_writer.sv
// -----------------------------------------------------------------------------
// weight_ram_writer
// Loads DEPTH words of WIDTH bits into the weight RAM from a byte stream,
// writing addresses 0..DEPTH-1 in order. The RAM itself sits beside this block.
//   clock, reset : clock, async active-low reset
//   start        : one-cycle pulse, begins a load (ignored while loading)
//   busy         : load in progress
//   done         : all words written; held until the next start
//   bus (slave)  : byte stream in, RAM write port out
//
// state | meaning
// IDLE  | after reset, waiting for start
// LOAD  | accepting bytes of the current word
// WRITE | one-cycle RAM write of the assembled word
// DONE  | all words written, waiting for start to reload
// -----------------------------------------------------------------------------
module weight_ram_writer
    import nn_pkg::*;
#(
    parameter int WIDTH = INT_WIDTH + FRAC_WIDTH,
    parameter int DEPTH = 784
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    weight_ram_writer_if.slave bus
);
    localparam int ADDR_WIDTH                 = addr_bits(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_width_check
        $error("weight_ram_writer: WIDTH (%0d) must be a non-zero multiple of 8", WIDTH);
    end

    loader_state_t         state;
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic                  accept;
    logic                  asm_clear;
    logic                  word_complete;
    logic [WIDTH-1:0]      word_full;

    // in_ready is registered and only high in LOAD, so accept never depends
    // combinationally on anything but in_valid and a flop.
    assign accept    = bus.in_valid && bus.in_ready;
    assign asm_clear = start && ((state == IDLE) || (state == DONE));

    byte_word_assembler #(
        .WIDTH (WIDTH)
    ) u_assembler (
        .clock         (clock),
        .reset         (reset),
        .clear         (asm_clear),
        .accept        (accept),
        .byte_in       (bus.in_data),
        .word_full     (word_full),
        .word_complete (word_complete)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            word_cnt          <= '0;
            bus.in_ready      <= 1'b0;
            bus.write_enable  <= 1'b0;
            bus.write_address <= '0;
            bus.write_data    <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= LOAD;
                        word_cnt     <= '0;
                        bus.in_ready <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                    end
                end
                LOAD: begin
                    if (word_complete) begin
                        state             <= WRITE;
                        bus.in_ready      <= 1'b0;
                        bus.write_enable  <= 1'b1;
                        bus.write_address <= word_cnt;
                        bus.write_data    <= word_full;
                    end
                end
                WRITE: begin
                    bus.write_enable <= 1'b0;
                    // Stop at the last address instead of incrementing so the
                    // counter never leaves 0..DEPTH-1.
                    if (word_cnt == LAST_ADDR) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state        <= LOAD;
                        word_cnt     <= word_cnt + ADDR_WIDTH'(1);
                        bus.in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_ram_writer.sv
// -----------------------------------------------------------------------------
// tb_weight_ram_writer
// Self-checking bench for weight_ram_writer (WIDTH=16, DEPTH=4). Expected
// writes are computed from the byte lists as little-endian words at
// consecutive addresses and compared against every observed write strobe.
// -----------------------------------------------------------------------------
module tb_weight_ram_writer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int BPW   = WIDTH / 8;

    logic clock = 1'b0;
    logic reset;
    logic start = 1'b0;
    logic busy;
    logic done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int   exp_addr[$];
    int   exp_data[$];
    int   we_cyc[$];
    int   last_we_cyc = -1;
    logic prev_we     = 1'b0;

    weight_ram_writer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    weight_ram_writer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: consecutive little-endian words from base address up.
    task automatic expect_words(input logic [7:0] b[$], input int base);
        int word;
        for (int w = 0; w < b.size() / BPW; w++) begin
            word = 0;
            for (int k = 0; k < BPW; k++) begin
                word = word + (int'(b[w*BPW + k]) << (8*k));
            end
            exp_addr.push_back(base + w);
            exp_data.push_back(word);
        end
    endtask

    // Write-port monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (bus.write_enable === 1'b1) begin
                chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
                chk("done_during_write", {31'd0, done}, 32'd0);
                if (exp_addr.size() == 0) begin
                    chk("unexpected_write", {31'd0, bus.write_enable}, 32'd0);
                end else begin
                    chk("write_address", 32'(bus.write_address), 32'(exp_addr.pop_front()));
                    chk("write_data", 32'(bus.write_data), 32'(exp_data.pop_front()));
                end
                we_cyc.push_back(cyc);
                last_we_cyc = cyc;
            end
            prev_we = bus.write_enable;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Offer bytes with in_valid asserted pct% of cycles; advance only on an
    // actual handshake. Returns at the negedge after the last acceptance.
    task automatic drive(input logic [7:0] b[$], input int pct);
        int   idx    = 0;
        int   budget = 3000;
        logic accepted;
        while (idx < b.size() && budget > 0) begin
            @(negedge clock);
            bus.in_data  = b[idx];
            bus.in_valid = (int'($urandom_range(99, 0)) < pct);
            accepted     = bus.in_valid && (bus.in_ready === 1'b1);
            @(posedge clock);
            if (accepted) idx++;
            budget--;
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
        chk("drive_bytes_accepted", 32'(idx), 32'(b.size()));
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        chk({tag, "_write_enable"}, {31'd0, bus.write_enable}, 32'd0);
        chk({tag, "_write_address"}, 32'(bus.write_address), 32'd0);
        chk({tag, "_write_data"}, 32'(bus.write_data), 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b[$];

        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        #2 reset     = 1'b0;
        #10;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b1;

        // Basic load, in_valid held high.
        b = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
        expect_words(b, 0);
        we_cyc.delete();
        pulse_start();
        chk("ready_after_start", {31'd0, bus.in_ready}, 32'd1);
        chk("busy_in_load", {31'd0, busy}, 32'd1);
        drive(b, 100);
        wait_done("done_basic");
        chk("done_latency", 32'(cyc - last_we_cyc), 32'd1);
        chk("basic_write_count", 32'(we_cyc.size()), 32'(DEPTH));
        for (int i = 1; i < we_cyc.size(); i++) begin
            chk("write_spacing", 32'(we_cyc[i] - we_cyc[i-1]), 32'(BPW + 1));
        end
        chk("basic_exp_left", 32'(exp_addr.size()), 32'd0);
        chk("busy_after_done", {31'd0, busy}, 32'd0);

        // Overrun after done: nothing consumed, nothing written.
        bus.in_data = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            bus.in_valid = 1'b1;
            chk("overrun_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("overrun_done", {31'd0, done}, 32'd1);
        end
        @(negedge clock);
        bus.in_valid = 1'b0;

        // Backpressure: same data, ~50% valid duty.
        expect_words(b, 0);
        pulse_start();
        drive(b, 50);
        wait_done("done_backpressure");
        chk("backpressure_exp_left", 32'(exp_addr.size()), 32'd0);

        // Reset in the middle of a word.
        b = '{8'h34};
        pulse_start();
        drive(b, 100);
        chk("ready_before_reset", {31'd0, bus.in_ready}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_addr.delete();
        exp_data.delete();
        @(negedge clock);
        reset = 1'b1;

        b = '{8'hAA, 8'h55};
        expect_words(b, 0);
        pulse_start();
        drive(b, 100);

        // Word 1, then a spurious start while loading, then words 2-3.
        b.delete();
        for (int i = 0; i < BPW; i++) b.push_back(8'($urandom));
        expect_words(b, 1);
        drive(b, 60);
        pulse_start();
        chk("spurious_start_busy", {31'd0, busy}, 32'd1);
        chk("spurious_start_ready", {31'd0, bus.in_ready}, 32'd1);
        b.delete();
        for (int i = 0; i < 2*BPW; i++) b.push_back(8'($urandom));
        expect_words(b, 2);
        drive(b, 60);
        wait_done("done_after_spurious");
        chk("spurious_exp_left", 32'(exp_addr.size()), 32'd0);

        // Reload from DONE.
        b.delete();
        for (int i = 0; i < DEPTH; i++) begin
            b.push_back(8'h01);
            b.push_back(8'h00);
        end
        expect_words(b, 0);
        pulse_start();
        chk("reload_done_cleared", {31'd0, done}, 32'd0);
        drive(b, 100);
        wait_done("done_reload");
        chk("reload_exp_left", 32'(exp_addr.size()), 32'd0);

        // Random loads with random duty.
        for (int r = 0; r < 3; r++) begin
            b.delete();
            for (int i = 0; i < DEPTH*BPW; i++) b.push_back(8'($urandom));
            expect_words(b, 0);
            pulse_start();
            drive(b, int'($urandom_range(100, 30)));
            wait_done("done_random");
            chk("random_exp_left", 32'(exp_addr.size()), 32'd0);
        end

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
